// File: rtl/slice_permute_unit.sv
`default_nettype none
// ============================================================================
//  Module   : slice_permute_unit
//  Brief    : Accepts one 25-bit Keccak state slice every two cycles after a
//             start handshake and presents its pi-permuted image. A control
//             FSM generates the slice-register load strobe. A bit-permutation
//             network drives the output from the slice register.
//  Revision : 1.0 - initial release
// ============================================================================
module slice_permute_unit #(
  parameter int LINE_W    = 25,
  parameter int NUM_LINES = 64
) (
  input  logic              clk,
  input  logic              rst,          // asynchronous, active-low
  input  logic              start,
  input  logic [LINE_W-1:0] line,
  output logic              lineRegLoad,
  output logic [LINE_W-1:0] newLine,
  output logic              busy
);

  // Slice counter width; kept at least one bit wide for degenerate frames.
  localparam int                 c_CNT_W = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;
  localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(NUM_LINES - 1);

  // Elaboration-time guards on unsupported configurations.
  if (LINE_W != 25) begin : g_bad_line_w
    $error("slice_permute_unit: LINE_W must be 25 (5x5 lanes)");
  end
  if ((NUM_LINES < 1) || (NUM_LINES > 64) ||
      ((NUM_LINES & (NUM_LINES - 1)) != 0)) begin : g_bad_num_lines
    $error("slice_permute_unit: NUM_LINES must be a power of two <= 64");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_LOAD = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [c_CNT_W-1:0]  r_cnt;
  logic [c_CNT_W-1:0]  w_cnt_next;
  logic                w_load;
  logic                w_busy;
  logic [LINE_W-1:0]   r_line;

  // State and slice-counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Next-state, counter update and Moore outputs. Start is only looked at in
  // IDLE and ARM, so a frame in flight can never be restarted.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_load       = 1'b0;
    w_busy       = 1'b1;
    unique case (r_state)
      ST_IDLE: begin
        w_busy = 1'b0;
        if (start) begin
          w_state_next = ST_ARM;
        end
      end
      ST_ARM: begin
        // A long start level yields a single frame that begins once it drops.
        if (!start) begin
          w_state_next = ST_LOAD;
        end
      end
      ST_LOAD: begin
        w_load       = 1'b1;
        w_state_next = ST_HOLD;
      end
      ST_HOLD: begin
        if (r_cnt == c_LAST) begin
          w_cnt_next   = '0;
          w_state_next = ST_IDLE;
        end else begin
          w_cnt_next   = r_cnt + 1'b1;
          w_state_next = ST_LOAD;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_cnt_next   = '0;
        w_busy       = 1'b0;
      end
    endcase
  end

  // Slice register: captures the input on the strobe edge, otherwise holds.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_line <= '0;
    end else if (w_load) begin
      r_line <= line;
    end
  end

  assign lineRegLoad = w_load;
  assign busy        = w_busy;

  // Pi step as pure wiring: lane (x,y) at bit 5y+x moves to lane
  // (y, (2x+3y) mod 5), i.e. bit 5*((2x+3y) mod 5) + y.
  for (genvar gy = 0; gy < 5; gy++) begin : g_pi_y
    for (genvar gx = 0; gx < 5; gx++) begin : g_pi_x
      localparam int c_SRC = 5 * gy + gx;
      localparam int c_DST = 5 * ((2 * gx + 3 * gy) % 5) + gy;
      assign newLine[c_DST] = r_line[c_SRC];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_slice_permute_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_slice_permute_unit
//  Brief    : Self-checking bench for slice_permute_unit. A scripted stimulus
//             process predicts the load cadence and queues the expected pi
//             image of every slice it offers; a monitor pops and compares on
//             each load strobe.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_slice_permute_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [24:0] line;
  logic        lineRegLoad;
  logic [24:0] newLine;
  logic        busy;

  typedef struct packed {
    logic [24:0] src;
    logic [24:0] pi;
  } exp_t;

  exp_t        exp_q[$];
  int          total;
  int          bad;
  int          strobes;
  logic [24:0] last_loaded;
  logic [24:0] sl [64];

  slice_permute_unit #(.LINE_W(25), .NUM_LINES(64)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .line        (line),
    .lineRegLoad (lineRegLoad),
    .newLine     (newLine),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference pi written as a gather: output lane (X,Y) comes from input
  // lane x = 3*(Y + 2X) mod 5, y = X (inverse of (x,y)->(y,2x+3y)).
  function automatic logic [24:0] pi_ref(input logic [24:0] a);
    logic [24:0] r;
    int sx;
    r = '0;
    for (int oy = 0; oy < 5; oy++) begin
      for (int ox = 0; ox < 5; ox++) begin
        sx = (3 * (oy + 2 * ox)) % 5;
        r[5 * oy + ox] = a[5 * ox + sx];
      end
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: on every load strobe, compare the presented image after the edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst === 1'b1 && lineRegLoad === 1'b1) begin
        strobes++;
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
          chk("scoreboard_underflow", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("newLine_vs_model", newLine, e.pi);
          chk("popcount", $countones(newLine), $countones(e.src));
        end
      end
    end
  end

  // Idle stretch: no strobes, not busy, image of the last loaded slice held.
  task automatic idle_check(input int n);
    int s0;
    s0 = strobes;
    for (int k = 0; k < n; k++) begin
      line = 25'($urandom);
      @(negedge clk);
    end
    chk("idle_no_strobe", strobes - s0, 0);
    chk("idle_busy", busy, 0);
    chk("idle_hold", newLine, pi_ref(last_loaded));
  endtask

  // One frame. Returns early if abort_at is reached (reset mid-frame).
  task automatic run_frame(input int nhigh, input int pulse_at, input int abort_at,
                           input bit known);
    int s0;
    logic [24:0] known_out [6];
    known_out = '{25'h0000001, 25'h0000400, 25'h0010000, 25'h0000010,
                  25'h0000000, 25'h1FFFFFF};
    s0 = strobes;
    for (int k = 0; k < nhigh; k++) begin
      start = 1'b1;
      line  = 25'($urandom);
      @(negedge clk);
      chk("arm_busy", busy, 1);
      chk("arm_no_strobe", lineRegLoad, 0);
    end
    start = 1'b0;
    for (int i = 0; i < 64; i++) begin
      line = sl[i];
      exp_q.push_back({sl[i], pi_ref(sl[i])});
      @(negedge clk);
      start = 1'b0;
      chk("load_strobe", lineRegLoad, 1);
      chk("busy_in_frame", busy, 1);
      @(negedge clk);
      chk("hold_no_strobe", lineRegLoad, 0);
      last_loaded = sl[i];
      if (known && i < 6) chk("known_map", newLine, known_out[i]);
      if (i == pulse_at) start = 1'b1;
      if (i == abort_at) begin
        rst = 1'b0;
        #1;
        chk("abort_newLine", newLine, 0);
        chk("abort_busy", busy, 0);
        chk("abort_strobe", lineRegLoad, 0);
        chk("abort_strobe_count", strobes - s0, abort_at + 1);
        last_loaded = '0;
        @(negedge clk);
        rst = 1'b1;
        return;
      end
    end
    @(negedge clk);
    chk("frame_end_busy", busy, 0);
    chk("frame_strobes", strobes - s0, 64);
    chk("frame_queue_empty", exp_q.size(), 0);
  endtask

  task automatic fill_random();
    for (int i = 0; i < 64; i++) sl[i] = 25'($urandom);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    total = 0;
    bad = 0;
    strobes = 0;
    last_loaded = '0;
    rst = 1'b0;
    start = 1'b0;
    line = 25'h1FFFFFF;
    repeat (2) @(negedge clk);
    chk("reset_newLine", newLine, 0);
    chk("reset_strobe", lineRegLoad, 0);
    chk("reset_busy", busy, 0);
    rst = 1'b1;
    idle_check(100);

    // Known single-bit and bulk vectors first, then random slices.
    fill_random();
    sl[0] = 25'h0000001; sl[1] = 25'h0000002; sl[2] = 25'h0000020;
    sl[3] = 25'h1000000; sl[4] = 25'h0000000; sl[5] = 25'h1FFFFFF;
    run_frame(3, -1, -1, 1'b1);
    idle_check(10);

    // Start pulse during HOLD of slice 10 must be ignored.
    fill_random();
    run_frame(1, 10, -1, 1'b0);
    idle_check(10);

    // Reset during slice 30 aborts; nothing resumes without a new start.
    fill_random();
    run_frame(2, -1, 30, 1'b0);
    chk("post_abort_queue", exp_q.size(), 0);
    idle_check(20);

    fill_random();
    run_frame(2, -1, -1, 1'b0);
    idle_check(10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/slice_permute_unit.md
Name: slice_permute_unit

Overview:
- Streams 64 consecutive 25-bit state slices through the Keccak pi step, one slice per two clock cycles.
- Contains a control FSM and a datapath. The FSM generates the slice-register load strobe after a start pulse. The datapath registers each slice and presents its pi-permuted image.
- Sits between a slice source (memory or file reader) and a slice sink inside the permutation-function pipeline.

Parameters:
- LINE_W, 25, slice width. Only 25 (5x5 lanes) is supported; any other value is a configuration error.
- NUM_LINES, 64, slices per frame. Must be a power of two, at most 64.

Ports:
- clk  in  1  single system clock, rising-edge active.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  frame start request, level-sampled on clk.
- line  in  LINE_W  input slice. Must be stable during the cycle in which lineRegLoad=1.
- lineRegLoad  out  1  slice-register load strobe; high for exactly one cycle per slice.
- newLine  out  LINE_W  pi-permuted contents of the slice register.
- busy  out  1  high while a frame is in progress.

Behaviour:
- Reset (rst=0, asynchronous):
  - FSM goes to IDLE; slice counter=0; slice register=0.
  - Outputs: newLine=0, lineRegLoad=0, busy=0.
  - Reset release is synchronous to clk.
- FSM states:
  - IDLE: busy=0. On start=1 go to ARM.
  - ARM: busy=1. Wait while start=1; on start=0 go to LOAD.
  - LOAD: lineRegLoad=1. Next state is HOLD.
  - HOLD: lineRegLoad=0. If counter==NUM_LINES-1: clear counter, go to IDLE. Otherwise increment counter, go to LOAD.
- Load cadence:
  - LOAD and HOLD alternate, so one slice is accepted every 2 cycles.
  - Exactly NUM_LINES load strobes occur per frame.
  - The first strobe occurs in the cycle after start is seen low.
- Datapath register:
  - On the rising edge where lineRegLoad=1, the slice register captures line.
  - Otherwise the register holds its value, including after the frame ends.
- Bit mapping: bit index i = 5*y + x, with x,y in 0..4.
- newLine is combinational from the slice register (pi step):
  - newLine[5*((2x+3y) mod 5) + y] = reg[5*y + x].
  - This is a pure bit permutation: no XOR, no constants.
- Latency: newLine reflects a slice from the load edge onward and stays valid for at least 2 cycles, until the next load edge.
- start handling:
  - start is ignored in LOAD and HOLD; a frame cannot be restarted mid-frame.
  - A start held high for many cycles produces one frame, begun after it falls.
- Reset mid-frame: aborts immediately. The remaining strobes are not issued, and the next frame requires a new start pulse.
- A start asserted in the same cycle reset releases is sampled on the first active edge only.

Test Plan:
- Reset: rst=0 with line=1FFFFFF -> newLine=0, lineRegLoad=0, busy=0. Release rst with no start -> no strobe for 100 cycles.
- Start handshake: start high 3 cycles then low -> busy=1 from the first edge.
  - First lineRegLoad occurs 1 cycle after start is sampled low.
  - Strobes then occur every 2nd cycle, 64 strobes total, then busy=0.
- Single-bit mapping (one bit per load, single bit set in line):
  - 0000001 -> 0000001
  - 0000002 -> 0000400 (bit1->bit10)
  - 0000020 -> 0010000 (bit5->bit16)
  - 1000000 -> 0000010 (bit24->bit4)
- Bulk patterns: all-zero -> 0; 1FFFFFF -> 1FFFFFF. For 64 random slices, popcount(newLine)==popcount(line), and each output matches the reference pi model.
- Robustness, part 1: a start pulse during HOLD of slice 10 -> ignored; exactly 64 strobes in the frame.
- Robustness, part 2: rst low during slice 30 -> immediate IDLE with newLine=0. The next start runs a full 64-slice frame.
